// File: rtl/fetch_stage_pkg.sv
// Shared types for the RV32I fetch stage: FSM state encoding, NOP encoding
// and the IF/ID payload.
package fetch_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_BOOT  = 2'd0,
        FS_FETCH = 2'd1,
        FS_DRAIN = 2'd2,
        FS_HOLD  = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response handshake between the fetch stage
// (master) and instruction memory (slave).
interface fetch_stage_if;

    logic                              imem_req;
    logic [fetch_stage_pkg::XLEN-1:0]  imem_addr;
    logic                              imem_ready;
    logic [fetch_stage_pkg::XLEN-1:0]  imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register {valid, pc, inst}; flush beats load, otherwise
// the contents are held.
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INST = INST_NOP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            flush,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_inst,
    output if_id_t          q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '{valid: 1'b0, pc: '0, inst: NOP_INST};
        end else if (flush) begin
            q.valid <= 1'b0;
            q.inst  <= NOP_INST;
        end else if (load) begin
            q <= '{valid: 1'b1, pc: load_pc, inst: load_inst};
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: PC register, variable-latency imem handshake and IF/ID
// register. Define FETCH_PERF_EN to add fetch/stall performance counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INST = INST_NOP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [XLEN-1:0]    npc,
    input  logic               jump,
    input  logic               stall,
    output logic [XLEN-1:0]    pc,
    fetch_stage_if.master      imem,
    output logic               if_id_valid,
    output logic [XLEN-1:0]    if_id_pc,
    output logic [XLEN-1:0]    if_id_inst,
    output logic               fetch_busy
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt
`endif
);

    fetch_state_e    state;
    logic            req;
    logic [XLEN-1:0] redir_pc;
    logic [XLEN-1:0] buf_pc;
    logic [XLEN-1:0] buf_inst;

    logic            ld_c;
    logic            fl_c;
    logic [XLEN-1:0] ld_pc_c;
    logic [XLEN-1:0] ld_inst_c;
    if_id_t          if_id;

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc;

    // State, PC, redirect target and hold buffer; imem_req/fetch_busy follow the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FS_BOOT;
            pc         <= RESET_PC;
            req        <= 1'b0;
            fetch_busy <= 1'b0;
            redir_pc   <= RESET_PC;
            buf_pc     <= RESET_PC;
            buf_inst   <= NOP_INST;
        end else begin
            case (state)
                FS_BOOT: begin
                    state <= FS_FETCH;
                    req   <= 1'b1;
                end
                FS_FETCH: begin
                    if (imem.imem_ready) begin
                        if (jump || !stall) begin
                            pc <= npc;
                        end else begin
                            buf_pc     <= pc;
                            buf_inst   <= imem.imem_rdata;
                            state      <= FS_HOLD;
                            req        <= 1'b0;
                            fetch_busy <= 1'b1;
                        end
                    end else if (jump) begin
                        redir_pc   <= npc;
                        state      <= FS_DRAIN;
                        fetch_busy <= 1'b1;
                    end
                end
                FS_DRAIN: begin
                    if (jump) redir_pc <= npc;
                    if (imem.imem_ready) begin
                        pc         <= jump ? npc : redir_pc;
                        state      <= FS_FETCH;
                        fetch_busy <= 1'b0;
                    end
                end
                FS_HOLD: begin
                    if (jump || !stall) begin
                        pc         <= npc;
                        state      <= FS_FETCH;
                        req        <= 1'b1;
                        fetch_busy <= 1'b0;
                    end
                end
                default: state <= FS_BOOT;
            endcase
        end
    end

    // IF/ID load/flush decode; jump outranks stall
    always_comb begin
        ld_c      = 1'b0;
        fl_c      = 1'b0;
        ld_pc_c   = pc;
        ld_inst_c = imem.imem_rdata;
        case (state)
            FS_FETCH: begin
                if (jump) begin
                    fl_c = 1'b1;
                end else if (!stall) begin
                    if (imem.imem_ready) ld_c = 1'b1;
                    else                 fl_c = 1'b1;
                end
            end
            FS_DRAIN: fl_c = 1'b1;
            FS_HOLD: begin
                if (jump) begin
                    fl_c = 1'b1;
                end else if (!stall) begin
                    ld_c      = 1'b1;
                    ld_pc_c   = buf_pc;
                    ld_inst_c = buf_inst;
                end
            end
            default: ;
        endcase
    end

    fetch_stage_if_id_reg #(.NOP_INST(NOP_INST)) u_if_id (
        .clk       (clk),
        .rst       (rst),
        .load      (ld_c),
        .flush     (fl_c),
        .load_pc   (ld_pc_c),
        .load_inst (ld_inst_c),
        .q         (if_id)
    );

    assign if_id_valid = if_id.valid;
    assign if_id_pc    = if_id.pc;
    assign if_id_inst  = if_id.inst;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if (ld_c) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (state == FS_HOLD || (state == FS_FETCH && stall))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a transaction-level reference
// model (outstanding fetch / pending redirect / parked instruction).
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump;
    logic        stall;
    logic [31:0] npc;
    logic [31:0] pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic        fetch_busy;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    fetch_stage_if imem ();

    fetch_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
        .clk         (clk),
        .rst         (rst),
        .npc         (npc),
        .jump        (jump),
        .stall       (stall),
        .pc          (pc),
        .imem        (imem),
        .if_id_valid (if_id_valid),
        .if_id_pc    (if_id_pc),
        .if_id_inst  (if_id_inst),
        .fetch_busy  (fetch_busy)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;
    bit check_en = 0;

    // Reference model: what the fetch unit is doing, not how it is encoded
    logic [31:0] m_pc;
    bit          m_boot;        // one idle cycle after reset
    bit          m_redirect;    // stale fetch in flight, target remembered
    logic [31:0] m_redir_pc;
    bit          m_parked;      // fetched instruction waiting for stall release
    logic [31:0] m_park_pc;
    logic [31:0] m_park_inst;
    bit          m_v;
    logic [31:0] m_ipc;
    logic [31:0] m_inst;
    logic [31:0] m_fcnt;
    logic [31:0] m_scnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        bit exp_req;
        exp_req = !m_boot && !m_parked;
        check("pc", pc, m_pc);
        check("imem_req", 32'(imem.imem_req), 32'(exp_req));
        if (exp_req) check("imem_addr", imem.imem_addr, m_pc);
        check("if_id_valid", 32'(if_id_valid), 32'(m_v));
        check("if_id_inst", if_id_inst, m_inst);
        if (m_v) check("if_id_pc", if_id_pc, m_ipc);
        check("fetch_busy", 32'(fetch_busy), 32'(m_redirect || m_parked));
`ifdef FETCH_PERF_EN
        check("perf_fetch_cnt", perf_fetch_cnt, m_fcnt);
        check("perf_stall_cnt", perf_stall_cnt, m_scnt);
`endif
    endtask

    task automatic bubble();
        m_v    = 1'b0;
        m_inst = NOP;
    endtask

    task automatic deliver(input logic [31:0] a, input logic [31:0] d);
        m_v    = 1'b1;
        m_ipc  = a;
        m_inst = d;
        m_fcnt = m_fcnt + 32'd1;
    endtask

    task automatic model_step();
        bit done;
        if (rst) begin
            m_pc = RST_PC; m_boot = 1; m_redirect = 0; m_parked = 0;
            m_v = 0; m_ipc = 32'd0; m_inst = NOP; m_fcnt = 32'd0; m_scnt = 32'd0;
            return;
        end
        if (m_parked || (!m_boot && !m_redirect && stall)) m_scnt = m_scnt + 32'd1;
        done = imem.imem_ready;
        if (m_boot) begin
            m_boot = 0;
        end else if (m_parked) begin
            if (jump) begin
                bubble(); m_pc = npc; m_parked = 0;
            end else if (!stall) begin
                deliver(m_park_pc, m_park_inst); m_pc = npc; m_parked = 0;
            end
        end else if (m_redirect) begin
            if (jump) m_redir_pc = npc;
            bubble();
            if (done) begin m_pc = m_redir_pc; m_redirect = 0; end
        end else if (jump) begin
            bubble();
            if (done) m_pc = npc;
            else begin m_redirect = 1; m_redir_pc = npc; end
        end else if (stall) begin
            if (done) begin m_parked = 1; m_park_pc = m_pc; m_park_inst = imem.imem_rdata; end
        end else if (done) begin
            deliver(m_pc, imem.imem_rdata); m_pc = npc;
        end else begin
            bubble();
        end
    endtask

    task automatic cycle(input bit r, input bit j, input bit s, input bit rdy, input logic [31:0] tgt);
        @(negedge clk);
        if (check_en) check_all();
        rst   = r;
        jump  = j;
        stall = s;
        imem.imem_ready = rdy;
        imem.imem_rdata = $urandom;
        npc   = j ? tgt : m_pc + 32'd4;
        @(posedge clk);
        model_step();
    endtask

    initial begin
        rst = 1'b1; jump = 1'b0; stall = 1'b0; npc = 32'd0;
        imem.imem_ready = 1'b0; imem.imem_rdata = 32'd0;

        cycle(1, 0, 0, 0, 0);
        check_en = 1;
        cycle(1, 0, 0, 1, 0);
        // streaming with zero-wait memory
        repeat (6) cycle(0, 0, 0, 1, 0);
        // wait states with stable address
        repeat (3) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        // stall while the response returns, then release
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        // redirect while waiting, late response discarded
        cycle(0, 1, 0, 0, 32'h40);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        repeat (2) cycle(0, 0, 0, 1, 0);
        // second redirect during drain wins
        cycle(0, 1, 0, 0, 32'h100);
        cycle(0, 1, 0, 0, 32'h200);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        // hold, then jump together with stall
        cycle(0, 0, 1, 1, 0);
        cycle(0, 1, 1, 0, 32'h80);
        repeat (2) cycle(0, 0, 0, 1, 0);
        // reset while draining
        cycle(0, 1, 0, 0, 32'h300);
        cycle(1, 0, 0, 1, 0);
        repeat (4) cycle(0, 0, 0, 1, 0);
        // pc wraps past 2^32
        cycle(0, 1, 0, 1, 32'hFFFF_FFF8);
        repeat (4) cycle(0, 0, 0, 1, 0);

        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 99) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom);
        end
        @(negedge clk);
        check_all();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- PC register, instruction-memory fetch handshake and IF/ID pipeline register for the pipelined RV32I core.
- Sits directly downstream of the next-PC logic:
  - consumes its `npc` and `jump` outputs;
  - feeds its `pc` output back as the next-PC PC input.
- Tolerates variable-latency instruction memory, hazard-unit stalls and redirect flushes.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded by reset.
- NOP_INST, 32'h0000_0013, instruction injected on bubble/flush (addi x0,x0,0).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- npc  in  32  next PC from next-PC logic; valid every cycle.
- jump  in  1  redirect taken (branch/jal/jalr); `npc` holds the target.
- stall  in  1  hazard-unit hold of IF/ID and PC.
- pc  out  32  current fetch PC; drives next-PC logic and `imem_addr`.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, equal to `pc`.
- imem_ready  in  1  memory accepted the request and returned `imem_rdata` this cycle.
- imem_rdata  in  32  fetched instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_pc  out  32  PC of the IF/ID instruction.
- if_id_inst  out  32  IF/ID instruction.
- fetch_busy  out  1  high in DRAIN or HOLD.

Behaviour:
- Reset (`rst`=1 at an edge):
  - `pc`=RESET_PC, `if_id_valid`=0, `if_id_inst`=NOP_INST, `if_id_pc`=0, hold buffer=NOP_INST, state=BOOT.
  - `imem_req`=0 in BOOT.
  - Reset mid-transaction abandons it; the late `imem_ready` is ignored because `imem_req`=0.
- States: BOOT, FETCH, DRAIN, HOLD.
- BOOT:
  - `imem_req`=0; goes to FETCH unconditionally the next cycle.
  - First request is therefore issued in cycle 2 after reset release.
- FETCH:
  - `imem_req`=1, `imem_addr`=`pc`.
  - `imem_addr` must stay stable until `imem_ready`.
  - Response rules:
    - ready & jump: IF/ID flushed (valid=0, inst=NOP_INST); `pc`<=`npc`; stay FETCH. Returned data discarded.
    - ready & stall & !jump: IF/ID held; `imem_rdata`/`pc` captured into hold buffer; state HOLD; `pc` unchanged.
    - ready & !stall & !jump: IF/ID<={1,`pc`,`imem_rdata`}; `pc`<=`npc`.
    - !ready & jump: `npc` latched into redirect register; IF/ID flushed; state DRAIN.
    - !ready & stall: IF/ID held.
    - !ready & neither: IF/ID bubble (valid=0, inst=NOP_INST).
- DRAIN:
  - `imem_req`=1 at the old `pc` until `imem_ready`; IF/ID is a bubble.
  - On ready: data discarded, `pc`<=redirect register, state FETCH.
  - A further jump in DRAIN overwrites the redirect register (the newest redirect wins).
- HOLD:
  - `imem_req`=0.
  - jump: buffer discarded, IF/ID flushed, `pc`<=`npc`, state FETCH.
  - !stall: IF/ID<=buffer (valid=1), `pc`<=`npc`, state FETCH.
  - Otherwise: hold.
- Priority:
  - `jump` over `stall` (the redirect resolves in a later stage and kills younger instructions).
  - `rst` over everything.
- Latency:
  - With zero-wait memory: one instruction per cycle; the instruction enters IF/ID on the edge after its request.
  - Redirect penalty: 1 bubble (zero-wait memory).
- `pc` is full 32-bit, wrapping modulo 2^32; bits [1:0] pass through unchecked.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds outputs `perf_fetch_cnt[31:0]` (increments on each IF/ID load with valid=1) and `perf_stall_cnt[31:0]` (increments each cycle in HOLD, or in FETCH with `stall`=1).
  - Both counters reset to 0 and wrap on overflow.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared header `ctrl_encode_def.v` holds:
  - state encodings `FS_BOOT`=2'd0, `FS_FETCH`=2'd1, `FS_DRAIN`=2'd2, `FS_HOLD`=2'd3;
  - `INST_NOP` 32'h0000_0013.
- One sub-module, if_id_reg:
  - 65-bit register {valid, pc, inst} with load/hold/flush controls and flush priority.
  - Instantiated once.

Test Plan:
- Zero-wait memory, no stall/jump, npc=pc+4 → `pc` goes 0,4,8,12; IF/ID valid from cycle 3 with pc 0,4,8.
- `imem_ready` low 3 cycles at pc=0x10 → `imem_addr` stable at 0x10, `imem_req`=1, IF/ID bubbles; on ready IF/ID={1,0x10,data}.
- `stall`=1 for 2 cycles while ready returns 0x00500093 at pc=0x8 → HOLD entered, `fetch_busy`=1; after release IF/ID={1,0x8,0x00500093} and `pc`=0xC.
- `jump`=1 with npc=0x40 while waiting at 0x20 → DRAIN entered; the late response is discarded; next request at 0x40; no valid IF/ID entry from 0x20.
- `jump` and `stall` both high in HOLD with npc=0x80 → IF/ID flushed (valid=0, inst=0x13); `pc`=0x80.
- `rst` asserted in DRAIN → next cycle `pc`=RESET_PC, `imem_req`=0, `if_id_valid`=0; fetching resumes at RESET_PC.
